decodificador_complemento_a_1: RTL and testbench
================================================

DECODIFICADOR_COMPLEMENTO_A_1 -- requirements
Module: decodificador_complemento_a_1

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-high reset.
REQ-002 Parameter DEBOUNCE_CYCLES, default 12000, SHALL set the number of consecutive stable cycles required to accept a button level.
REQ-003 Parameter BLINK_HALF, default 6000000, SHALL set the half-period in cycles of the sign-LED blink.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 BTN1..BTN4  input  1 each  raw, asynchronous, bouncing buttons carrying code bits 0..3; BTN4 is the sign bit.
REQ-007 LED0..LED2  output  1 each  decoded magnitude bits 0..2.
REQ-008 LED3  output  1  sign indicator, 1 = negative.
REQ-009 LED4  output  1  negative-zero flag, 1 when the code is 1111.
REQ-010 UPD  output  1  single-cycle pulse on each display update.

Function
REQ-011 Each BTNn SHALL pass through a 2-flop synchronizer before debouncing.
REQ-012 A debounced bit SHALL adopt a new level only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to the old level SHALL restart the count from 0.
REQ-013 The code SHALL be {db4,db3,db2,db1}, interpreted as 4-bit ones' complement.
REQ-014 The FSM SHALL have states IDLE, UPDATE and SHOW.
REQ-015 IDLE SHALL go to UPDATE unconditionally on the next cycle.
REQ-016 UPDATE SHALL latch the code, drive the decoded outputs, assert UPD for that one cycle, and go to SHOW.
REQ-017 SHOW SHALL go to UPDATE on the cycle after the debounced code differs from the latched code, and stay in SHOW otherwise.
REQ-018 Decode: if code[3]=0, magnitude = code[2:0] and sign = 0.
REQ-019 Decode: if code[3]=1, magnitude = ~code[2:0] and sign = 1.
REQ-020 Negative zero (code 1111) SHALL be normalized: magnitude 000, LED3 = 0, LED4 = 1; LED4 SHALL be 0 for every other code.
REQ-021 Latency from a clean BTN edge to the LED change SHALL be exactly DEBOUNCE_CYCLES+3 cycles, with UPD high on the cycle in which the LEDs change.
REQ-022 Several buttons changing in the same cycle SHALL produce one update; buttons settling on different cycles SHALL produce one update each.
REQ-023 A bounce that dies out before reaching DEBOUNCE_CYCLES SHALL produce no UPD and no LED change.

Reset
REQ-024 While rst = 1, LED0..LED4 and UPD SHALL be 0, debounced bits, synchronizers and counters SHALL be 0, and the FSM SHALL be in IDLE.
REQ-025 rst asserted mid-debounce or mid-blink SHALL discard the partial count immediately and asynchronously.
REQ-026 After rst is released, the first UPDATE SHALL display code 0000, i.e. all LEDs 0, with UPD pulsing.

Configuration
REQ-027 With macro COMPLEMENTO_BLINK_EN defined, LED3 SHALL toggle every BLINK_HALF cycles while the latched value is negative.
REQ-028 Under COMPLEMENTO_BLINK_EN, the blink counter SHALL restart on each UPDATE so that LED3 = 1 on the update cycle.
REQ-029 Under COMPLEMENTO_BLINK_EN, LED3 SHALL be 0 while the latched value is non-negative.
REQ-030 With COMPLEMENTO_BLINK_EN undefined, LED3 SHALL be the steady sign and no blink counter SHALL exist.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (IDLE, UPDATE, SHOW), the code width (4), the magnitude width (3) and the default DEBOUNCE_CYCLES and BLINK_HALF values.
REQ-032 The synchronizer and debouncer SHALL form sub-module antirrebote, instantiated four times.

Verification (DEBOUNCE_CYCLES=4, BLINK_HALF=8)
REQ-033 Release rst with all BTN=0 -> one UPD pulse, LED0..LED4 = 0.
REQ-034 Apply code 0101 cleanly -> 7 cycles later UPD=1, LED2..0=101, LED3=0, LED4=0.
REQ-035 Apply code 1010 -> LED2..0=101 and LED3=1; with COMPLEMENTO_BLINK_EN defined, LED3 toggles every 8 cycles.
REQ-036 Apply code 1111 -> LED2..0=000, LED3=0, LED4=1.
REQ-037 Toggle BTN2 for 3 cycles, then return it to its old level -> no UPD, LEDs unchanged.
REQ-038 Assert rst 2 cycles into a debounce of BTN1 -> all outputs 0 at once; after release, BTN1 needs a full 4 stable cycles to be accepted.

Source files
------------

// File: rtl/decodificador_complemento_a_1_pkg.sv
// Shared types and constants for the ones'-complement button decoder.
// Holds the FSM state enum, code/magnitude widths, parameter defaults and the decode helper.
package decodificador_complemento_a_1_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        SHOW   = 2'd2
    } estado_t;

    localparam int unsigned CODE_W              = 4;
    localparam int unsigned MAG_W               = 3;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 12000;
    localparam int unsigned BLINK_HALF_DEF      = 6000000;

    typedef struct packed {
        logic [MAG_W-1:0] mag;
        logic             sign;
        logic             neg_zero;
    } decoded_t;

    // 1111 is negative zero: shown as +0 with its own flag instead of a lit sign.
    function automatic decoded_t decode_c1(input logic [CODE_W-1:0] code);
        decoded_t d;
        d.mag      = '0;
        d.sign     = 1'b0;
        d.neg_zero = 1'b0;
        if (code == '1) begin
            d.neg_zero = 1'b1;
        end else if (code[CODE_W-1]) begin
            d.mag  = ~code[MAG_W-1:0];
            d.sign = 1'b1;
        end else begin
            d.mag = code[MAG_W-1:0];
        end
        return d;
    endfunction

endpackage

// File: rtl/decodificador_complemento_a_1_antirrebote.sv
// Two-flop synchronizer followed by a consecutive-cycle debouncer for one raw button.
// The debounced level flips only after DEBOUNCE_CYCLES unbroken cycles at the new level.
module antirrebote
    import decodificador_complemento_a_1_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic db
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;

    always_comb begin
        sync_d = {sync_q[0], btn};
        cnt_d  = cnt_q;
        db_d   = db_q;
        if (sync_q[1] != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = sync_q[1];
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            // Any glitch back to the accepted level restarts the run.
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/decodificador_complemento_a_1.sv
// Debounces four buttons into a 4-bit ones'-complement code and shows sign/magnitude on LEDs.
// Optional macro COMPLEMENTO_BLINK_EN makes the sign LED blink while the shown value is negative.
module decodificador_complemento_a_1
    import decodificador_complemento_a_1_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned BLINK_HALF      = BLINK_HALF_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic BTN1,
    input  logic BTN2,
    input  logic BTN3,
    input  logic BTN4,
    output logic LED0,
    output logic LED1,
    output logic LED2,
    output logic LED3,
    output logic LED4,
    output logic UPD
);

    if (DEBOUNCE_CYCLES < 1 || BLINK_HALF < 1) begin : g_param_check
        $error("DEBOUNCE_CYCLES and BLINK_HALF must both be at least 1");
    end

    logic [CODE_W-1:0] btn_raw;
    logic [CODE_W-1:0] code;

    assign btn_raw = {BTN4, BTN3, BTN2, BTN1};

    for (genvar i = 0; i < int'(CODE_W); i++) begin : g_antirrebote
        antirrebote #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_antirrebote (
            .clk(clk),
            .rst(rst),
            .btn(btn_raw[i]),
            .db (code[i])
        );
    end

    estado_t           state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [MAG_W-1:0]  mag_q, mag_d;
    logic              sign_q, sign_d;
    logic              nz_q, nz_d;
    logic              upd_q, upd_d;
    logic              load;
    decoded_t          dec;

    // Outputs are loaded on the edge that enters UPDATE, so LEDs and UPD change together.
    always_comb begin
        dec     = decode_c1(code);
        load    = 1'b0;
        state_d = state_q;
        case (state_q)
            IDLE:    load = 1'b1;
            UPDATE:  state_d = SHOW;
            SHOW:    load = (code != code_q);
            default: state_d = IDLE;
        endcase
        code_d = code_q;
        mag_d  = mag_q;
        sign_d = sign_q;
        nz_d   = nz_q;
        upd_d  = load;
        if (load) begin
            state_d = UPDATE;
            code_d  = code;
            mag_d   = dec.mag;
            sign_d  = dec.sign;
            nz_d    = dec.neg_zero;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
            mag_q   <= '0;
            sign_q  <= 1'b0;
            nz_q    <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            mag_q   <= mag_d;
            sign_q  <= sign_d;
            nz_q    <= nz_d;
            upd_q   <= upd_d;
        end
    end

    assign LED0 = mag_q[0];
    assign LED1 = mag_q[1];
    assign LED2 = mag_q[2];
    assign LED4 = nz_q;
    assign UPD  = upd_q;

`ifdef COMPLEMENTO_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               led3_q, led3_d;

    // Restart the half-period on every update so a negative value starts lit.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        led3_d      = led3_q;
        if (load) begin
            blink_cnt_d = '0;
            led3_d      = dec.sign;
        end else if (sign_q) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                led3_d      = ~led3_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end else begin
            blink_cnt_d = '0;
            led3_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            led3_q      <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            led3_q      <= led3_d;
        end
    end

    assign LED3 = led3_q;
`else
    assign LED3 = sign_q;
`endif

endmodule

// File: tb/tb_decodificador_complemento_a_1.sv
// Self-checking bench for decodificador_complemento_a_1 with DEBOUNCE_CYCLES=4, BLINK_HALF=8.
// A sample-window model predicts every output each cycle; directed literals pin key points.
module tb_decodificador_complemento_a_1;

    localparam int N  = 4;
    localparam int BH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic BTN1 = 1'b0, BTN2 = 1'b0, BTN3 = 1'b0, BTN4 = 1'b0;
    logic LED0, LED1, LED2, LED3, LED4, UPD;

    always #5 clk = ~clk;

    decodificador_complemento_a_1 #(
        .DEBOUNCE_CYCLES(N),
        .BLINK_HALF(BH)
    ) dut (
        .clk(clk), .rst(rst),
        .BTN1(BTN1), .BTN2(BTN2), .BTN3(BTN3), .BTN4(BTN4),
        .LED0(LED0), .LED1(LED1), .LED2(LED2), .LED3(LED3), .LED4(LED4),
        .UPD(UPD)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int upd_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int outs();
        return int'({LED4, LED3, LED2, LED1, LED0, UPD});
    endfunction

    // Ones' complement by arithmetic: negative codes are -(15 - code); 1111 is -0.
    function automatic void decode_m(input int code, output int mag, output bit neg, output bit nz);
        int v;
        nz  = (code == 15);
        v   = (code >= 8) ? -(15 - code) : code;
        neg = (v < 0);
        mag = neg ? -v : v;
    endfunction

    // Model: a raw level is accepted once N consecutive samples, delayed two clocks, all disagree
    // with the accepted level; the display picks up a changed code one cycle later, never on two
    // consecutive cycles, and the first cycle after reset always refreshes.
    bit hist [4][$];
    bit db_m [4];
    int shown_m  = 0;
    bit upd_m    = 1'b0;
    bit first_m  = 1'b1;
    int since_m  = 0;
    int db_code_m;
    bit [3:0] raw_m;
    bit all_m;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                hist[i].delete();
                for (int j = 0; j < N + 2; j++) hist[i].push_back(1'b0);
                db_m[i] = 1'b0;
            end
            shown_m = 0;
            upd_m   = 1'b0;
            first_m = 1'b1;
            since_m = 0;
        end else begin
            db_code_m = 0;
            for (int i = 0; i < 4; i++) if (db_m[i]) db_code_m += (1 << i);
            if (first_m || (!upd_m && db_code_m != shown_m)) begin
                upd_m   = 1'b1;
                shown_m = db_code_m;
                since_m = 0;
                first_m = 1'b0;
            end else begin
                upd_m = 1'b0;
                since_m++;
            end
            raw_m = {BTN4, BTN3, BTN2, BTN1};
            for (int i = 0; i < 4; i++) begin
                hist[i].push_back(raw_m[i]);
                while (hist[i].size() > N + 2) void'(hist[i].pop_front());
                all_m = 1'b1;
                for (int j = 0; j < N; j++) if (hist[i][j] == db_m[i]) all_m = 1'b0;
                if (all_m) db_m[i] = ~db_m[i];
            end
        end
    end

    always @(negedge clk) begin
        int  mag;
        bit  neg, nz, led3e;
        int  exp;
        decode_m(shown_m, mag, neg, nz);
        led3e = neg;
`ifdef COMPLEMENTO_BLINK_EN
        led3e = neg && (((since_m / BH) % 2) == 0);
`endif
        exp = (int'(nz) << 5) | (int'(led3e) << 4) | ((mag & 7) << 1) | int'(upd_m);
        check("model", outs(), exp);
        if (UPD) upd_seen++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_code(input logic [3:0] c);
        {BTN4, BTN3, BTN2, BTN1} = c;
    endtask

    int base;

    initial begin
        step(3);
        check("reset_outputs", outs(), 0);
        rst = 1'b0;
        step(1);
        check("first_upd", outs(), 6'b000001);
        step(1);
        check("first_upd_low", outs(), 6'b000000);
        step(3);

        set_code(4'b0101);
        step(6);
        check("c0101_before", outs(), 6'b000000);
        step(1);
        check("c0101_upd", outs(), 6'b001011);
        step(1);
        check("c0101_hold", outs(), 6'b001010);
        step(5);

        base = upd_seen;
        set_code(4'b1010);
        step(7);
        check("c1010_upd", outs(), 6'b011011);
        step(8);
`ifdef COMPLEMENTO_BLINK_EN
        check("c1010_blink_off", outs(), 6'b001010);
`else
        check("c1010_steady", outs(), 6'b011010);
`endif
        step(8);
        check("c1010_later", outs(), 6'b011010);
        check("c1010_single_upd", upd_seen - base, 1);

        set_code(4'b1111);
        step(7);
        check("c1111_upd", outs(), 6'b100001);
        step(3);

        base = upd_seen;
        BTN2 = 1'b0;
        step(3);
        BTN2 = 1'b1;
        step(15);
        check("bounce_no_upd", upd_seen - base, 0);
        check("bounce_leds", outs(), 6'b100000);

        base = upd_seen;
        BTN1 = 1'b0;
        step(2);
        BTN2 = 1'b0;
        step(20);
        check("stagger_two_upd", upd_seen - base, 2);
        check("stagger_mag", int'({LED4, LED2, LED1, LED0}), 4'b0011);

        BTN1 = 1'b1;
        step(2);
        #1 rst = 1'b1;
        #1 check("async_reset", outs(), 0);
        step(2);
        rst = 1'b0;
        step(1);
        check("post_rst_first_upd", outs(), 6'b000001);
        step(5);
        check("post_rst_wait", outs(), 6'b000000);
        step(1);
        check("post_rst_accept", outs(), 6'b010101);
        step(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
